block_sync: RTL and testbench
=============================

Name: block_sync

Overview:
- Per-lane 64b/66b block-lock stage for the 40GbE receive path.
- Sits between the rx gearbox and alignment marker extraction; one instance per PCS lane (4 total).
- Inspects the 2-bit sync header of each 66-bit block, hunts for block boundary by issuing bitslip pulses to the gearbox, and reports block_locked.
- Lock/unlock rules follow the Clause 82 lock state machine (64 good headers to lock, 16 bad in 64 to unlock).

Parameters:
- LOCK_CNT, 64: consecutive valid headers required to declare lock.
- WINDOW_CNT, 64: header window size while locked.
- INVALID_LIMIT, 16: invalid headers within one window that cause loss of lock.
- SLIP_WAIT, 4: cycles after a bitslip pulse during which headers are ignored (gearbox settle time).
- HI_BER_WINDOW, 19531: headers per hi-BER window (125 us at 156.25 MHz).
- HI_BER_LIMIT, 16: invalid headers per hi-BER window that assert hi_ber.

Ports:
- clk  input  1  core clock.
- reset  input  1  asynchronous, active-low reset.
- sync_valid  input  1  a new block header is present this cycle.
- sync_bits  input  2  sync header of the current block.
- bitslip  output  1  single-cycle request to the gearbox to slip one bit.
- block_locked  output  1  lane is block-locked.
- hi_ber  output  1  high bit-error-rate indication.
- slip_count  output  8  saturating count of bitslips since reset.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values: bitslip=0, block_locked=0, hi_ber=0, slip_count=0, state=S_HUNT, all counters 0. Reset asserted mid-operation clears everything immediately; no pending slip survives reset.
- Header classification: valid = sync_bits is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
- Qualification: only cycles with sync_valid=1 are evaluated. With sync_valid=0, all counters and state hold.
- S_HUNT:
  - Valid header: sh_cnt++.
  - Valid header with sh_cnt == LOCK_CNT-1: block_locked<=1 on the next edge, go to S_LOCKED, clear counters.
  - Invalid header: bitslip<=1 for one cycle, sh_cnt<=0, slip_count++ (saturates at 255), go to S_SLIP.
- S_SLIP:
  - Wait counter runs SLIP_WAIT cycles regardless of sync_valid; headers are ignored.
  - Then return to S_HUNT.
  - Consequence: bitslip pulses are separated by at least SLIP_WAIT+1 cycles.
- S_LOCKED:
  - Each qualified header: sh_cnt++; invalid headers also increment inv_cnt.
  - Invalid header bringing inv_cnt to INVALID_LIMIT: block_locked<=0, bitslip pulse, slip_count++, go to S_SLIP.
  - Header bringing sh_cnt to WINDOW_CNT without reaching the limit: clear both counters, stay locked.
  - Simultaneous events: if the final header of a window is the INVALID_LIMIT-th invalid, loss of lock wins.
- Latency: all outputs are registered. Status changes one clock after the qualifying header is sampled.
- Counter widths: sh_cnt 7 bits, inv_cnt 5 bits, slip wait counter $clog2(SLIP_WAIT+1) bits. No wrap-around is possible, because counters clear before overflow.

Optional Feature:
- Macro BLOCK_SYNC_HI_BER_EN.
- Defined:
  - Hi-BER monitor active while block_locked=1. Counts qualified headers up to HI_BER_WINDOW; invalid headers increment a saturating ber_cnt.
  - hi_ber<=1 when ber_cnt reaches HI_BER_LIMIT.
  - At window end, if ber_cnt < HI_BER_LIMIT: hi_ber<=0. Window and ber_cnt then restart.
  - Loss of lock clears the window and ber_cnt; hi_ber holds its value until the next completed window.
- Not defined: hi_ber tied 0 and no monitor logic is synthesized.

Decomposition:
- Shared package pcs_pkg:
  - SH_DATA=2'b01 and SH_CTRL=2'b10 constants.
  - sync_state_t enum (S_HUNT, S_SLIP, S_LOCKED).
  - Default LOCK_CNT / INVALID_LIMIT constants, reused by the tx encoder and the alignment stage.
- One sub-module: hi_ber_monitor, instantiated only under BLOCK_SYNC_HI_BER_EN.

Test Plan:
- Reset, then 63 headers of 2'b01 -> block_locked=0. The 64th header -> block_locked=1 on the next cycle, bitslip never pulses.
- Unlocked, one header of 2'b11 -> bitslip=1 for exactly one cycle, slip_count=1, next 4 headers ignored. A subsequent 64 valid headers -> lock.
- Locked, 15 invalid headers spread over one 64-header window -> stays locked. Next window with 16 invalid -> block_locked=0 and bitslip pulses the cycle after the 16th.
- Locked, 16th invalid header arrives as header 64 of the window -> lock lost, not a window reset.
- sync_valid toggled 50% during a 64-good sequence -> lock asserts after exactly 64 qualified headers. Reset asserted at header 40 -> all outputs 0 immediately.
- With BLOCK_SYNC_HI_BER_EN, HI_BER_WINDOW=100, HI_BER_LIMIT=4, locked:
  - 4 invalid headers spaced 20 apart (below the 16-in-64 unlock rule) -> hi_ber=1.
  - Next window fully clean -> hi_ber=0 at window end.

Source files
------------

// File: rtl/pcs_pkg.sv
// Shared 40GbE PCS types and constants.
// Used by block lock, the tx encoder and the alignment stage.
package pcs_pkg;

  localparam logic [1:0] SH_DATA = 2'b01;
  localparam logic [1:0] SH_CTRL = 2'b10;

  localparam int LOCK_CNT_DEF      = 64;
  localparam int INVALID_LIMIT_DEF = 16;

  typedef enum logic [1:0] {
    S_HUNT,
    S_SLIP,
    S_LOCKED
  } sync_state_t;

  function automatic logic sh_ok(
    input logic [1:0] sh
  );
    return (sh == SH_DATA) || (sh == SH_CTRL);
  endfunction

endpackage

// File: rtl/block_sync_if.sv
// Header feed from the rx gearbox and lock status back.
// master = gearbox side, slave = block_sync.
interface block_sync_if;

  logic       sync_valid;
  logic [1:0] sync_bits;
  logic       bitslip;
  logic       block_locked;
  logic       hi_ber;
  logic [7:0] slip_count;

  modport master (
    output sync_valid,
    output sync_bits,
    input  bitslip,
    input  block_locked,
    input  hi_ber,
    input  slip_count
  );

  modport slave (
    input  sync_valid,
    input  sync_bits,
    output bitslip,
    output block_locked,
    output hi_ber,
    output slip_count
  );

endinterface

// File: rtl/hi_ber_monitor.sv
// Hi-BER window monitor, built only with BLOCK_SYNC_HI_BER_EN.
// Counts bad headers per window while the lane is locked.
module hi_ber_monitor #(
  parameter int WINDOW = 19531,
  parameter int LIMIT  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic locked,
  input  logic hdr_valid,
  input  logic hdr_bad,
  output logic hi_ber
);

  localparam int CW = $clog2(WINDOW + 1);
  localparam int BW = $clog2(LIMIT + 1);

  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW - 1);
  localparam logic [BW-1:0] BER_MAX  = BW'(LIMIT);

  logic [CW-1:0] win_q;
  logic [BW-1:0] ber_q;
  logic [BW-1:0] ber_nx;
  logic          hi_q;

  // ber_cnt saturates at the limit, so "below limit" == "not at max"
  assign ber_nx = (hdr_bad && ber_q != BER_MAX)
                ? ber_q + BW'(1) : ber_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q <= '0;
      ber_q <= '0;
      hi_q  <= 1'b0;
    end else if (!locked) begin
      win_q <= '0;
      ber_q <= '0;
    end else if (hdr_valid) begin
      if (ber_nx == BER_MAX)
        hi_q <= 1'b1;
      if (win_q == WIN_LAST) begin
        win_q <= '0;
        ber_q <= '0;
        if (ber_nx != BER_MAX)
          hi_q <= 1'b0;
      end else begin
        win_q <= win_q + CW'(1);
        ber_q <= ber_nx;
      end
    end
  end

  assign hi_ber = hi_q;

endmodule

// File: rtl/block_sync.sv
// Per-lane 64b/66b block lock with bitslip hunting.
// Define BLOCK_SYNC_HI_BER_EN to build the hi-BER monitor.
module block_sync
  import pcs_pkg::*;
#(
  parameter int LOCK_CNT      = LOCK_CNT_DEF,
  parameter int WINDOW_CNT    = 64,
  parameter int INVALID_LIMIT = INVALID_LIMIT_DEF,
  parameter int SLIP_WAIT     = 4,
  parameter int HI_BER_WINDOW = 19531,
  parameter int HI_BER_LIMIT  = 16
) (
  input logic         clk,
  input logic         reset,
  block_sync_if.slave sb
);

  localparam int WW = $clog2(SLIP_WAIT + 1);

  localparam logic [6:0]    LOCK_LAST = 7'(LOCK_CNT - 1);
  localparam logic [6:0]    WIN_LAST  = 7'(WINDOW_CNT - 1);
  localparam logic [4:0]    INV_LAST  = 5'(INVALID_LIMIT - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(SLIP_WAIT - 1);

  sync_state_t   state_q, state_d;
  logic [6:0]    sh_q, sh_d;
  logic [4:0]    inv_q, inv_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [7:0]    slips_q, slips_d;
  logic          slip_q, slip_d;
  logic          lock_q, lock_d;
  logic          take_slip;
  logic          good;
  logic          hi_ber_w;

  assign good = sh_ok(sb.sync_bits);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_HUNT;
      sh_q    <= '0;
      inv_q   <= '0;
      wait_q  <= '0;
      slips_q <= '0;
      slip_q  <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      inv_q   <= inv_d;
      wait_q  <= wait_d;
      slips_q <= slips_d;
      slip_q  <= slip_d;
      lock_q  <= lock_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    inv_d     = inv_q;
    wait_d    = wait_q;
    slips_d   = slips_q;
    slip_d    = 1'b0;
    lock_d    = lock_q;
    take_slip = 1'b0;

    unique case (state_q)
      S_HUNT: begin
        if (sb.sync_valid) begin
          if (!good) begin
            take_slip = 1'b1;
          end else if (sh_q == LOCK_LAST) begin
            lock_d  = 1'b1;
            state_d = S_LOCKED;
            sh_d    = '0;
            inv_d   = '0;
          end else begin
            sh_d = sh_q + 7'd1;
          end
        end
      end
      S_SLIP: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_HUNT;
        end else begin
          wait_d = wait_q + WW'(1);
        end
      end
      S_LOCKED: begin
        // loss of lock outranks the end-of-window clear
        if (sb.sync_valid) begin
          if (!good && inv_q == INV_LAST) begin
            lock_d    = 1'b0;
            take_slip = 1'b1;
          end else if (sh_q == WIN_LAST) begin
            sh_d  = '0;
            inv_d = '0;
          end else begin
            sh_d  = sh_q + 7'd1;
            inv_d = inv_q + {4'd0, ~good};
          end
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (take_slip) begin
      slip_d  = 1'b1;
      sh_d    = '0;
      inv_d   = '0;
      wait_d  = '0;
      state_d = S_SLIP;
      if (slips_q != 8'hff)
        slips_d = slips_q + 8'd1;
    end
  end

`ifdef BLOCK_SYNC_HI_BER_EN
  hi_ber_monitor #(
    .WINDOW (HI_BER_WINDOW),
    .LIMIT  (HI_BER_LIMIT)
  ) u_hi_ber (
    .clk       (clk),
    .reset     (reset),
    .locked    (lock_q),
    .hdr_valid (sb.sync_valid),
    .hdr_bad   (~good),
    .hi_ber    (hi_ber_w)
  );
`else
  logic unused_ber_cfg;
  assign unused_ber_cfg = (HI_BER_WINDOW > 0)
                        ^ (HI_BER_LIMIT > 0);
  assign hi_ber_w = 1'b0;
`endif

  assign sb.bitslip      = slip_q;
  assign sb.block_locked = lock_q;
  assign sb.hi_ber       = hi_ber_w;
  assign sb.slip_count   = slips_q;

endmodule

// File: tb/tb_block_sync.sv
// Bench for block_sync: directed scenarios plus random headers.
// Reference model tracks lock rules as plain run/window tallies.
`timescale 1ns/1ps
module tb_block_sync;

`ifdef BLOCK_SYNC_HI_BER_EN
  localparam int HBW = 100;
  localparam int HBL = 4;
`else
  localparam int HBW = 19531;
  localparam int HBL = 16;
`endif
  localparam int LOCK_N = 64;
  localparam int WIN_N  = 64;
  localparam int INV_N  = 16;
  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  block_sync_if bus();

  block_sync #(
    .HI_BER_WINDOW (HBW),
    .HI_BER_LIMIT  (HBL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus)
  );

  always #5 clk = ~clk;

  logic [10:0] dutv;
  assign dutv = {bus.bitslip, bus.block_locked,
                 bus.hi_ber, bus.slip_count};

  bit e_lock, e_slip, e_hiber;
  int e_slips, run, settle, wh, wb, bw, bb;

  function automatic logic [10:0] expv();
    return {e_slip, e_lock, e_hiber, 8'(e_slips)};
  endfunction

  task automatic model_reset();
    e_lock = 0; e_slip = 0; e_hiber = 0;
    e_slips = 0; run = 0; settle = 0;
    wh = 0; wb = 0; bw = 0; bb = 0;
  endtask

  task automatic model_slip();
    e_slip = 1;
    if (e_slips < 255) e_slips++;
    settle = SETTLE;
    run = 0; wh = 0; wb = 0;
  endtask

  // drive one cycle, advance the model at the edge, return at edge+1
  task automatic step(input bit v, input logic [1:0] b);
    bit badh, was;
    bus.sync_valid = v;
    bus.sync_bits = b;
    @(posedge clk);
    badh = (b == 2'b00) || (b == 2'b11);
    was = e_lock;
    e_slip = 0;
`ifdef BLOCK_SYNC_HI_BER_EN
    if (!was) begin
      bw = 0; bb = 0;
    end else if (v) begin
      bw++;
      if (badh && bb < HBL) bb++;
      if (bb >= HBL) e_hiber = 1;
      if (bw == HBW) begin
        if (bb < HBL) e_hiber = 0;
        bw = 0; bb = 0;
      end
    end
`endif
    if (settle > 0) begin
      settle--;
    end else if (v && !was) begin
      if (badh) model_slip();
      else begin
        run++;
        if (run == LOCK_N) begin
          e_lock = 1; run = 0; wh = 0; wb = 0;
        end
      end
    end else if (v) begin
      wh++;
      if (badh) wb++;
      if (badh && wb == INV_N) begin
        e_lock = 0;
        model_slip();
      end else if (wh == WIN_N) begin
        wh = 0; wb = 0;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    bus.sync_valid = 1'b0;
    bus.sync_bits = 2'b00;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    bus.sync_valid = 1'b0;
    bus.sync_bits = 2'b00;
    model_reset();
    #12;
    total++;
    if (dutv !== 11'd0) begin
      bad++;
      $display("FAIL reset: got %h want %h", dutv, 11'd0);
    end
    reset = 1'b1;
    step(1'b0, 2'b01);
    total++;
    if (dutv !== expv()) begin
      bad++;
      $display("FAIL reset_idle: got %h want %h", dutv, expv());
    end
  endtask

  task automatic test_lock();
    for (int i = 0; i < LOCK_N; i++) begin
      step(1'b1, 2'b01);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL lock[%0d]: got %h want %h", i, dutv, expv());
      end
      if (i == LOCK_N - 2) begin
        total++;
        if (bus.block_locked !== 1'b0) begin
          bad++;
          $display("FAIL lock_63: got %b want 0", bus.block_locked);
        end
      end
    end
    total++;
    if (bus.block_locked !== 1'b1 || bus.slip_count !== 8'd0) begin
      bad++;
      $display("FAIL lock_64: got %b/%0d want 1/0",
               bus.block_locked, bus.slip_count);
    end
  endtask

  task automatic test_slip();
    apply_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 2'b10);
    step(1'b1, 2'b11);
    total++;
    if (bus.bitslip !== 1'b1 || bus.slip_count !== 8'd1) begin
      bad++;
      $display("FAIL slip_pulse: got %b/%0d want 1/1",
               bus.bitslip, bus.slip_count);
    end
    // invalid headers inside the settle time must not slip again
    for (int i = 0; i < SETTLE; i++) begin
      step(1'b1, 2'b11);
      total++;
      if (dutv !== expv() || bus.bitslip !== 1'b0) begin
        bad++;
        $display("FAIL slip_wait[%0d]: got %h want %h", i, dutv, expv());
      end
    end
    for (int i = 0; i < LOCK_N; i++) begin
      step(1'b1, (i % 2) ? 2'b01 : 2'b10);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL slip_relock[%0d]: got %h want %h", i, dutv, expv());
      end
    end
    total++;
    if (bus.block_locked !== 1'b1 || bus.slip_count !== 8'd1) begin
      bad++;
      $display("FAIL slip_lock: got %b/%0d want 1/1",
               bus.block_locked, bus.slip_count);
    end
  endtask

  task automatic test_unlock();
    logic [1:0] b;
    apply_reset();
    for (int i = 0; i < LOCK_N; i++) step(1'b1, 2'b01);
    for (int h = 0; h < WIN_N; h++) begin
      b = (h % 4 == 0 && h < 60) ? 2'b00 : 2'b01;
      step(1'b1, b);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL unlock_w1[%0d]: got %h want %h", h, dutv, expv());
      end
    end
    total++;
    if (bus.block_locked !== 1'b1) begin
      bad++;
      $display("FAIL unlock_15: got %b want 1", bus.block_locked);
    end
    for (int h = 0; h <= 45; h++) begin
      b = (h % 3 == 0) ? 2'b11 : 2'b10;
      step(1'b1, b);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL unlock_w2[%0d]: got %h want %h", h, dutv, expv());
      end
    end
    total++;
    if (bus.block_locked !== 1'b0 || bus.bitslip !== 1'b1) begin
      bad++;
      $display("FAIL unlock_16: got %b/%b want 0/1",
               bus.block_locked, bus.bitslip);
    end
  endtask

  task automatic test_window_edge();
    logic [1:0] b;
    apply_reset();
    for (int i = 0; i < LOCK_N; i++) step(1'b1, 2'b01);
    for (int h = 0; h < WIN_N; h++) begin
      b = ((h % 4 == 0 && h < 60) || h == 63) ? 2'b00 : 2'b01;
      step(1'b1, b);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL edge[%0d]: got %h want %h", h, dutv, expv());
      end
    end
    total++;
    if (bus.block_locked !== 1'b0 || bus.bitslip !== 1'b1
        || bus.slip_count !== 8'd1) begin
      bad++;
      $display("FAIL edge_last: got %b/%b/%0d want 0/1/1",
               bus.block_locked, bus.bitslip, bus.slip_count);
    end
  endtask

  task automatic test_gaps();
    int q;
    int n;
    bit v;
    apply_reset();
    q = 0;
    n = 0;
    while (q < LOCK_N && n < 1000) begin
      v = 1'($urandom_range(0, 1));
      step(v, v ? 2'b01 : 2'($urandom));
      if (v) q++;
      n++;
      total++;
      if (dutv !== expv() || (q < LOCK_N && bus.block_locked !== 1'b0)) begin
        bad++;
        $display("FAIL gaps[%0d]: got %h want %h", n, dutv, expv());
      end
    end
    total++;
    if (q != LOCK_N || bus.block_locked !== 1'b1) begin
      bad++;
      $display("FAIL gaps_lock: got %b after %0d hdrs want 1 after 64",
               bus.block_locked, q);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 40; i++) step(1'b1, 2'b01);
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10);
    step(1'b1, 2'b00);
    reset = 1'b0;
    #1;
    model_reset();
    total++;
    if (dutv !== 11'd0) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", dutv, 11'd0);
    end
    reset = 1'b1;
    // a stale slip state would swallow the first headers
    for (int i = 0; i < LOCK_N; i++) begin
      step(1'b1, 2'b01);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL reset_relock[%0d]: got %h want %h", i, dutv, expv());
      end
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 1400; i++) begin
      step(1'b1, (i % 2) ? 2'b00 : 2'b11);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL sat[%0d]: got %h want %h", i, dutv, expv());
      end
    end
    total++;
    if (bus.slip_count !== 8'd255) begin
      bad++;
      $display("FAIL sat_end: got %0d want 255", bus.slip_count);
    end
  endtask

  task automatic test_random();
    int rate;
    bit v;
    logic [1:0] b;
    apply_reset();
    for (int i = 0; i < 4000; i++) begin
      case ((i / 500) % 4)
        0: rate = 0;
        1: rate = 20;
        2: rate = 100;
        default: rate = 300;
      endcase
      v = ($urandom % 4) != 0;
      if (($urandom % 1000) < rate)
        b = ($urandom % 2) ? 2'b00 : 2'b11;
      else
        b = ($urandom % 2) ? 2'b01 : 2'b10;
      step(v, b);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL rand[%0d]: got %h want %h", i, dutv, expv());
      end
    end
  endtask

`ifdef BLOCK_SYNC_HI_BER_EN
  task automatic test_hi_ber();
    apply_reset();
    for (int i = 0; i < LOCK_N; i++) step(1'b1, 2'b01);
    for (int h = 0; h < 80; h++) begin
      step(1'b1, (h % 20 == 19) ? 2'b00 : 2'b01);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL hiber[%0d]: got %h want %h", h, dutv, expv());
      end
    end
    total++;
    if (bus.hi_ber !== 1'b1 || bus.block_locked !== 1'b1) begin
      bad++;
      $display("FAIL hiber_set: got %b/%b want 1/1",
               bus.hi_ber, bus.block_locked);
    end
    for (int h = 0; h < 120; h++) begin
      step(1'b1, 2'b10);
      total++;
      if (dutv !== expv()) begin
        bad++;
        $display("FAIL hiber_clean[%0d]: got %h want %h", h, dutv, expv());
      end
      if (h == 118 || h == 119) begin
        total++;
        if (bus.hi_ber !== (h == 118)) begin
          bad++;
          $display("FAIL hiber_clr[%0d]: got %b want %b",
                   h, bus.hi_ber, h == 118);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_lock();
    test_slip();
    test_unlock();
    test_window_edge();
    test_gaps();
    test_reset_mid();
    test_saturate();
    test_random();
`ifdef BLOCK_SYNC_HI_BER_EN
    test_hi_ber();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
